// File: rtl/int_sequencer_if.sv
// Core-side handshake between the bus/decode stage and the interrupt sequencer.
interface int_sequencer_if;
  logic        sync;
  logic [7:0]  data_i;
  logic [7:0]  pstatus_i;
  logic        vec_ack;
  logic [7:0]  opcode_o;
  logic        opcode_valid;
  logic        inject;
  logic        pc_hold;
  logic        push_inhibit;
  logic        b_flag;
  logic [1:0]  int_kind;
  logic [15:0] vector;

  modport master (
    output sync, data_i, pstatus_i, vec_ack,
    input  opcode_o, opcode_valid, inject, pc_hold, push_inhibit,
           b_flag, int_kind, vector
  );

  modport slave (
    input  sync, data_i, pstatus_i, vec_ack,
    output opcode_o, opcode_valid, inject, pc_hold, push_inhibit,
           b_flag, int_kind, vector
  );
endinterface

// File: rtl/int_sequencer.sv
// Opcode-fetch interrupt sequencer: passes fetched opcodes or forces BRK for
// pending RESET/NMI/IRQ, and supplies the matching vector and push controls.
module int_sequencer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] RESET_VEC   = 16'hFFFC,
  parameter logic [15:0] NMI_VEC     = 16'hFFFA,
  parameter logic [15:0] IRQ_VEC     = 16'hFFFE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             irq_n,
  input  logic             nmi_n,
  int_sequencer_if.slave   bus
);

  typedef enum logic {IDLE, SERVICE} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] irq_sync, nmi_sync;
  logic        nmi_s_d, nmi_edge, irq_act;
  logic        nmi_pend, rst_pend;
  logic        clr_nmi, clr_rst;

  logic [7:0]  opcode_nxt;
  logic        valid_nxt, inject_nxt, pc_hold_nxt, push_inh_nxt, b_flag_nxt;
  logic [1:0]  kind_nxt;
  logic [15:0] vector_nxt;

  assign nmi_edge = nmi_s_d & ~nmi_sync[SYNC_STAGES-1];
  assign irq_act  = ~irq_sync[SYNC_STAGES-1] & ~bus.pstatus_i[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_sync <= '1;
      nmi_sync <= '1;
      nmi_s_d  <= 1'b1;
      nmi_pend <= 1'b0;
      rst_pend <= 1'b1;
    end else begin
      irq_sync <= {irq_sync[SYNC_STAGES-2:0], irq_n};
      nmi_sync <= {nmi_sync[SYNC_STAGES-2:0], nmi_n};
      nmi_s_d  <= nmi_sync[SYNC_STAGES-1];
      // A new edge wins over clearing, so it is never lost behind a service.
      nmi_pend <= nmi_edge | (nmi_pend & ~clr_nmi);
      rst_pend <= rst_pend & ~clr_rst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      bus.opcode_o     <= 8'h00;
      bus.opcode_valid <= 1'b0;
      bus.inject       <= 1'b0;
      bus.pc_hold      <= 1'b0;
      bus.push_inhibit <= 1'b0;
      bus.b_flag       <= 1'b0;
      bus.int_kind     <= 2'd3;
      bus.vector       <= RESET_VEC;
    end else begin
      state            <= state_nxt;
      bus.opcode_o     <= opcode_nxt;
      bus.opcode_valid <= valid_nxt;
      bus.inject       <= inject_nxt;
      bus.pc_hold      <= pc_hold_nxt;
      bus.push_inhibit <= push_inh_nxt;
      bus.b_flag       <= b_flag_nxt;
      bus.int_kind     <= kind_nxt;
      bus.vector       <= vector_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (bus.sync && (rst_pend || nmi_pend || irq_act || bus.data_i == 8'h00))
          state_nxt = SERVICE;
      SERVICE:
        if (bus.vec_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    opcode_nxt   = bus.opcode_o;
    valid_nxt    = 1'b0;
    inject_nxt   = bus.inject;
    pc_hold_nxt  = bus.pc_hold;
    push_inh_nxt = bus.push_inhibit;
    b_flag_nxt   = bus.b_flag;
    kind_nxt     = bus.int_kind;
    vector_nxt   = bus.vector;
    clr_nmi      = 1'b0;
    clr_rst      = 1'b0;
    unique case (state)
      IDLE:
        if (bus.sync) begin
          valid_nxt = 1'b1;
          if (rst_pend || nmi_pend || irq_act) begin
            opcode_nxt   = 8'h00;
            inject_nxt   = 1'b1;
            pc_hold_nxt  = 1'b1;
            b_flag_nxt   = 1'b0;
            push_inh_nxt = rst_pend;
            if (rst_pend) begin
              kind_nxt   = 2'd3;
              vector_nxt = RESET_VEC;
              clr_rst    = 1'b1;
            end else if (nmi_pend) begin
              kind_nxt   = 2'd2;
              vector_nxt = NMI_VEC;
              clr_nmi    = 1'b1;
            end else begin
              kind_nxt   = 2'd1;
              vector_nxt = IRQ_VEC;
            end
          end else begin
            opcode_nxt  = bus.data_i;
            inject_nxt  = 1'b0;
            pc_hold_nxt = 1'b0;
            if (bus.data_i == 8'h00) begin
              b_flag_nxt = 1'b1;
              kind_nxt   = 2'd0;
              vector_nxt = IRQ_VEC;
            end
          end
        end
      SERVICE:
        if (bus.vec_ack) begin
          inject_nxt   = 1'b0;
          pc_hold_nxt  = 1'b0;
          push_inh_nxt = 1'b0;
        end
      default: ;
    endcase
  end

endmodule
